// File: rtl/proc_fetch_seq.sv
// Instruction sequencer for proc_fsm: small program memory, in-order fetch/issue, done handshake.
// Optional WAIT timeout fault enabled by defining SEQ_TIMEOUT_EN.
module proc_fetch_seq #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 8,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [DATA_W+7:0] prog_data,
    input  logic              start,
    input  logic              done,
    output logic              w,
    output logic [1:0]        F,
    output logic [1:0]        Rx,
    output logic [1:0]        Ry,
    output logic [DATA_W-1:0] din,
    output logic [AW-1:0]     pc,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    localparam int unsigned IW = DATA_W + 8;

    typedef enum logic [2:0] {StIdle, StFetch, StIssue, StWait, StHalt} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   mem [DEPTH];
    logic [IW-1:0]   ir_q, ir_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic            err_q, err_d;
    logic            ir_halt;
    logic            last_addr;
    logic            prog_open;
    logic            timed_out;

    assign ir_halt   = ir_q[DATA_W+1];
    assign last_addr = (pc_q == AW'(DEPTH - 1));
    assign prog_open = (state_q == StIdle) || (state_q == StHalt);

    // Program memory is never reset so a program survives rst_n.
    always_ff @(posedge clk) begin
        if (prog_we && prog_open) begin
            mem[prog_addr] <= prog_data;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

    // Cleared during ISSUE so the count starts at zero on the first WAIT cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIssue) begin
            cnt_d = '0;
        end else if (state_q == StWait && !timed_out) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign timed_out      = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                ir_d    = mem[pc_q];
                state_d = StIssue;
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (done) begin
                    if (ir_halt || last_addr) begin
                        state_d = StHalt;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = StFetch;
                    end
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (start) begin
                    err_d   = 1'b0;
                    pc_d    = '0;
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
        end
    end

    logic unused_reserved;
    assign unused_reserved = ir_q[DATA_W];

    assign w      = (state_q == StIssue);
    assign busy   = (state_q == StFetch) || (state_q == StIssue) || (state_q == StWait);
    assign halted = (state_q == StHalt);
    assign err    = err_q;
    assign pc     = pc_q;
    assign F      = ir_q[DATA_W+7:DATA_W+6];
    assign Rx     = ir_q[DATA_W+5:DATA_W+4];
    assign Ry     = ir_q[DATA_W+3:DATA_W+2];
    assign din    = ir_q[DATA_W-1:0];

endmodule
